// File: rtl/mem_arbiter.sv
// Two-requester (CPU / DMA) arbiter in front of a synchronous single-port memory.
// Each access walks IDLE -> ACCESS -> CAPTURE -> IDLE. The requester's done pulse
// and rdata update land in the cycle after CAPTURE.
// Build option: define ARB_CPU_PRIORITY_EN to make the CPU win every tie.
// When it is undefined, ties are resolved round-robin using last_served.
module mem_arbiter (
    input  logic       Clk,
    input  logic       Reset,

    input  logic       cpu_req,
    input  logic       cpu_write,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_gnt,
    output logic       cpu_done,
    output logic [7:0] cpu_rdata,

    input  logic       dma_req,
    input  logic       dma_write,
    input  logic [7:0] dma_addr,
    input  logic [7:0] dma_wdata,
    output logic       dma_gnt,
    output logic       dma_done,
    output logic [7:0] dma_rdata,

    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_write,
    input  logic [7:0] mem_rdata,

    output logic       busy
);

    localparam int unsigned DW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t state;
    logic   last_served;   // 1 = DMA owns (or last owned) the memory
    logic   lat_write;     // latched direction of the access in flight
    logic   pick_dma;

    // Winner selection for the current IDLE cycle; only consumed in IDLE.
    always_comb begin
        pick_dma = 1'b0;
`ifdef ARB_CPU_PRIORITY_EN
        pick_dma = dma_req && !cpu_req;
`else
        pick_dma = dma_req && (!cpu_req || !last_served);
`endif
    end

    // Access sequencer: state, grants, memory drive, capture and done pulses.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            last_served <= 1'b1;
            lat_write   <= 1'b0;
            cpu_gnt     <= 1'b0;
            dma_gnt     <= 1'b0;
            cpu_done    <= 1'b0;
            dma_done    <= 1'b0;
            cpu_rdata   <= DW'(0);
            dma_rdata   <= DW'(0);
            mem_addr    <= DW'(0);
            mem_wdata   <= DW'(0);
            mem_write   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            cpu_done <= 1'b0;
            dma_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req || dma_req) begin
                        state       <= ACCESS;
                        busy        <= 1'b1;
                        last_served <= pick_dma;
                        cpu_gnt     <= !pick_dma;
                        dma_gnt     <= pick_dma;
                        lat_write   <= pick_dma ? dma_write : cpu_write;
                        mem_write   <= pick_dma ? dma_write : cpu_write;
                        mem_addr    <= pick_dma ? dma_addr  : cpu_addr;
                        mem_wdata   <= pick_dma ? dma_wdata : cpu_wdata;
                    end
                end
                ACCESS: begin
                    state     <= CAPTURE;
                    cpu_gnt   <= 1'b0;
                    dma_gnt   <= 1'b0;
                    mem_write <= 1'b0;
                end
                CAPTURE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    cpu_done <= !last_served;
                    dma_done <= last_served;
                    if (!lat_write) begin
                        if (last_served) begin
                            dma_rdata <= mem_rdata;
                        end else begin
                            cpu_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cpu_gnt   <= 1'b0;
                    dma_gnt   <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed accesses with a done/rdata
// scoreboard, tie arbitration, late request, reset abort and random exclusivity.
module tb_mem_arbiter;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       cpu_req, cpu_write;
    logic [7:0] cpu_addr, cpu_wdata;
    logic       cpu_gnt, cpu_done;
    logic [7:0] cpu_rdata;
    logic       dma_req, dma_write;
    logic [7:0] dma_addr, dma_wdata;
    logic       dma_gnt, dma_done;
    logic [7:0] dma_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_write;
    logic       busy;

    mem_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_write(dma_write), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 Clk = ~Clk;

    // Synchronous memory, one-cycle read latency; contents loaded once at the first edge.
    logic [7:0] mem [256];
    logic       mem_loaded = 1'b0;
    always @(posedge Clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h10] <= 8'hA5;
            mem[8'h40] <= 8'h11;
            mem[8'h41] <= 8'h22;
            mem_loaded <= 1'b1;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    typedef struct packed {
        logic       dma;
        logic [7:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   sb_en  = 1'b1;
    int   grants_seen = 0;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expectation per done pulse, checks exclusivity every cycle.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                check1("excl_gnt",  cpu_gnt && dma_gnt, 1'b0);
                check1("excl_done", cpu_done && dma_done, 1'b0);
            end
            if (sb_en && (cpu_done || dma_done)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_done: got cpu_done=%0b dma_done=%0b, expected none",
                             cpu_done, dma_done);
                end else begin
                    e = exp_q.pop_front();
                    check1("sb_who", dma_done, e.dma);
                    check8("sb_rdata", dma_done ? dma_rdata : cpu_rdata, e.rdata);
                end
            end
        end
    endtask

    task automatic do_reset();
        Reset   = 1'b1;
        cpu_req = 1'b0;
        dma_req = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        tick();
    endtask

    // One isolated access with cycle-by-cycle checks of the handshake and memory drive.
    task automatic single_access(input string tag, input bit use_dma, input bit wr,
                                 input logic [7:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] exp_rdata);
        exp_q.push_back('{dma: use_dma, rdata: exp_rdata});
        if (use_dma) begin
            dma_req = 1'b1; dma_write = wr; dma_addr = addr; dma_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_write = wr; cpu_addr = addr; cpu_wdata = wdata;
        end
        tick();
        check1({tag, "_gnt"},       use_dma ? dma_gnt : cpu_gnt, 1'b1);
        check1({tag, "_other_gnt"}, use_dma ? cpu_gnt : dma_gnt, 1'b0);
        check8({tag, "_mem_addr"},  mem_addr, addr);
        check1({tag, "_mem_write"}, mem_write, wr);
        if (wr) check8({tag, "_mem_wdata"}, mem_wdata, wdata);
        check1({tag, "_busy_acc"},  busy, 1'b1);
        if (use_dma) dma_req = 1'b0; else cpu_req = 1'b0;
        tick();
        check1({tag, "_gnt_drop"},  use_dma ? dma_gnt : cpu_gnt, 1'b0);
        check1({tag, "_wr_drop"},   mem_write, 1'b0);
        check8({tag, "_addr_hold"}, mem_addr, addr);
        check1({tag, "_early_done"}, use_dma ? dma_done : cpu_done, 1'b0);
        tick();
        check1({tag, "_done"},  use_dma ? dma_done : cpu_done, 1'b1);
        check8({tag, "_rdata"}, use_dma ? dma_rdata : cpu_rdata, exp_rdata);
        check1({tag, "_busy_idle"}, busy, 1'b0);
        tick();
        check1({tag, "_done_pulse"}, use_dma ? dma_done : cpu_done, 1'b0);
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cpu_gnt || dma_gnt) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout: got no grant in 20 cycles, expected a grant");
        end
    endtask

    initial begin
        bit         ok;
        bit         got_dma;
        logic [4:0] exp_order;

        Reset = 1'b1;
        cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        dma_req = 1'b0; dma_write = 1'b0; dma_addr = 8'h00; dma_wdata = 8'h00;

        fork
            monitor();
            begin
                #100000;
                $display("FAIL watchdog: got timeout, expected completion");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset values.
        repeat (3) tick();
        check1("rst_cpu_gnt", cpu_gnt, 1'b0);
        check1("rst_dma_gnt", dma_gnt, 1'b0);
        check1("rst_cpu_done", cpu_done, 1'b0);
        check1("rst_dma_done", dma_done, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_mem_write", mem_write, 1'b0);
        check8("rst_mem_addr", mem_addr, 8'h00);
        check8("rst_mem_wdata", mem_wdata, 8'h00);
        check8("rst_cpu_rdata", cpu_rdata, 8'h00);
        check8("rst_dma_rdata", dma_rdata, 8'h00);
        Reset = 1'b0;
        tick();

        // Directed single accesses.
        single_access("cpu_rd",  1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
        single_access("dma_wr",  1'b1, 1'b1, 8'h20, 8'h3C, 8'h00);
        check8("mem_20_written", mem[8'h20], 8'h3C);
        single_access("dma_rd",  1'b1, 1'b0, 8'h20, 8'h00, 8'h3C);
        single_access("cpu_wr",  1'b0, 1'b1, 8'h30, 8'h5A, 8'hA5);
        check8("mem_30_written", mem[8'h30], 8'h5A);
        single_access("cpu_rd2", 1'b0, 1'b0, 8'h30, 8'h00, 8'h5A);
        check8("dma_rdata_kept", dma_rdata, 8'h3C);

        // Ties after reset.
        do_reset();
`ifdef ARB_CPU_PRIORITY_EN
        exp_order = 5'b10000;
`else
        exp_order = 5'b01010;
`endif
        for (int g = 0; g < 5; g++)
            exp_q.push_back('{dma: exp_order[g], rdata: exp_order[g] ? 8'h22 : 8'h11});
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h40;
        dma_req = 1'b1; dma_write = 1'b0; dma_addr = 8'h41;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(ok);
            if (!ok) break;
            got_dma = dma_gnt;
            check1($sformatf("tie_grant%0d", g), got_dma, exp_order[g]);
            if (got_dma) dma_req = 1'b0; else cpu_req = 1'b0;
            tick();
            if (g < 3) begin
                if (got_dma) dma_req = 1'b1; else cpu_req = 1'b1;
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        repeat (4) tick();

        // Late DMA request raised during the CPU's CAPTURE cycle.
        exp_q.push_back('{dma: 1'b0, rdata: 8'hA5});
        exp_q.push_back('{dma: 1'b1, rdata: 8'h22});
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h10;
        tick();
        check1("late_cpu_gnt", cpu_gnt, 1'b1);
        cpu_req = 1'b0;
        tick();
        dma_req = 1'b1; dma_write = 1'b0; dma_addr = 8'h41;
        check1("late_no_gnt_capture", dma_gnt, 1'b0);
        tick();
        check1("late_no_gnt_idle", dma_gnt, 1'b0);
        check1("late_cpu_done", cpu_done, 1'b1);
        tick();
        check1("late_dma_gnt", dma_gnt, 1'b1);
        check1("late_busy", busy, 1'b1);
        dma_req = 1'b0;
        repeat (4) tick();
        check8("sb_queue_empty", 8'(exp_q.size()), 8'h00);

        // Reset in the ACCESS cycle of a CPU write.
        cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 8'h50; cpu_wdata = 8'h77;
        tick();
        check1("abort_mem_write_acc", mem_write, 1'b1);
        #1;
        Reset = 1'b1;
        #1;
        check1("abort_mem_write", mem_write, 1'b0);
        check1("abort_busy", busy, 1'b0);
        check1("abort_cpu_gnt", cpu_gnt, 1'b0);
        check8("abort_cpu_rdata", cpu_rdata, 8'h00);
        cpu_req = 1'b0;
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check1($sformatf("abort_no_done%0d", i), cpu_done, 1'b0);
        end
        check8("abort_mem_50", mem[8'h50], 8'h00);

        // Random protocol-respecting traffic for exclusivity.
        sb_en = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (cpu_gnt || dma_gnt) grants_seen++;
            if (cpu_req && cpu_gnt) cpu_req = 1'b0;
            else if (!cpu_req && $urandom_range(0, 2) == 0) begin
                cpu_req = 1'b1; cpu_write = 1'($urandom_range(0, 1));
                cpu_addr = 8'($urandom); cpu_wdata = 8'($urandom);
            end
            if (dma_req && dma_gnt) dma_req = 1'b0;
            else if (!dma_req && $urandom_range(0, 2) == 0) begin
                dma_req = 1'b1; dma_write = 1'($urandom_range(0, 1));
                dma_addr = 8'($urandom); dma_wdata = 8'($urandom);
            end
            tick();
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        repeat (6) tick();
        check1("random_progress", grants_seen > 100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
